// File: rtl/kb_event_ctrl.sv
// rtl/kb_event_ctrl.sv - PS/2 set-2 scan-code prefix FSM, game-key held tracking and event FIFO
module kb_event_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code,
    input  logic       code_valid,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_data,
    output logic       space_held,
    output logic       up_held,
    output logic       down_held,
    output logic       overflow,
    output logic       seq_abort
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      held_q, held_d;
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic [2:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            seq_abort_q, seq_abort_d;

    logic            dec_en, dec_ext, dec_brk;
    logic            key_hit;
    logic [1:0]      key_id;
    logic            push, pop, push_ok, full;
    logic [2:0]      push_data;

    // Prefix state machine and stall timer; a byte arriving on the expiry cycle takes priority
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        seq_abort_d = 1'b0;
        dec_en      = 1'b0;
        dec_ext     = 1'b0;
        dec_brk     = 1'b0;
        if (code_valid) begin
            timer_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (code == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else if (code == CODE_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        dec_en = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (code == CODE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (code != CODE_EXT) begin
                        dec_en  = 1'b1;
                        dec_ext = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    dec_en  = 1'b1;
                    dec_brk = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    dec_en  = 1'b1;
                    dec_ext = 1'b1;
                    dec_brk = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timer_q == TMAX) begin
                state_d     = ST_IDLE;
                timer_d     = '0;
                seq_abort_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // Key decode and held tracking; repeats of a held key and breaks of an idle key are ignored
    always_comb begin
        key_hit   = 1'b0;
        key_id    = 2'd0;
        held_d    = held_q;
        push      = 1'b0;
        push_data = 3'd0;
        if (dec_en) begin
            case (code)
                CODE_SPACE: begin
                    key_hit = !dec_ext;
                    key_id  = 2'd0;
                end
                CODE_UP: begin
                    key_hit = 1'b1;
                    key_id  = 2'd1;
                end
                CODE_DOWN: begin
                    key_hit = 1'b1;
                    key_id  = 2'd2;
                end
                default: key_hit = 1'b0;
            endcase
        end
        if (key_hit) begin
            if (!dec_brk && !held_q[key_id]) begin
                held_d[key_id] = 1'b1;
                push           = 1'b1;
                push_data      = {1'b1, key_id};
            end else if (dec_brk && held_q[key_id]) begin
                held_d[key_id] = 1'b0;
                push           = 1'b1;
                push_data      = {1'b0, key_id};
            end
        end
    end

    // Event FIFO bookkeeping; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        mem_d      = mem_q;
        full       = (count_q == DEPTH_C);
        pop        = (count_q != '0) && evt_ready;
        push_ok    = push && (!full || pop);
        overflow_d = push && full && !pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers with asynchronous clear of everything, including queued events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            held_q      <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            seq_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            held_q      <= held_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            seq_abort_q <= seq_abort_d;
        end
    end

    assign evt_valid  = (count_q != '0);
    assign evt_data   = mem_q[rd_ptr_q];
    assign space_held = held_q[0];
    assign up_held    = held_q[1];
    assign down_held  = held_q[2];
    assign overflow   = overflow_q;
    assign seq_abort  = seq_abort_q;

endmodule

// File: tb/tb_kb_event_ctrl.sv
// tb/tb_kb_event_ctrl.sv - directed self-checking bench for kb_event_ctrl
module tb_kb_event_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] code;
    logic       code_valid;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_data;
    logic       space_held;
    logic       up_held;
    logic       down_held;
    logic       overflow;
    logic       seq_abort;

    int checks = 0;
    int errors = 0;

    kb_event_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (code),
        .code_valid (code_valid),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .space_held (space_held),
        .up_held    (up_held),
        .down_held  (down_held),
        .overflow   (overflow),
        .seq_abort  (seq_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        code       = b;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic pop_exp(input string tag, input logic [2:0] exp);
        chk({tag, "_valid"}, 8'(evt_valid), 8'h1);
        chk({tag, "_data"}, 8'(evt_data), 8'(exp));
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        code       = 8'h00;
        code_valid = 1'b0;
        evt_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 8'(evt_valid), 8'h0);
        chk("rst_data", 8'(evt_data), 8'h0);
        chk("rst_held", 8'({down_held, up_held, space_held}), 8'h0);
        chk("rst_ovf", 8'(overflow), 8'h0);
        chk("rst_abort", 8'(seq_abort), 8'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // space press/release with consumer always ready
        evt_ready = 1'b1;
        send(8'h29);
        chk("sp_press_valid", 8'(evt_valid), 8'h1);
        chk("sp_press_data", 8'(evt_data), 8'h4);
        chk("sp_held1", 8'(space_held), 8'h1);
        send(8'hF0);
        send(8'h29);
        chk("sp_rel_valid", 8'(evt_valid), 8'h1);
        chk("sp_rel_data", 8'(evt_data), 8'h0);
        chk("sp_held0", 8'(space_held), 8'h0);
        @(negedge clk);
        evt_ready = 1'b0;
        chk("sp_drained", 8'(evt_valid), 8'h0);

        // typematic repeats on up produce no extra events
        send(8'hE0);
        send(8'h75);
        send(8'h75);
        send(8'h75);
        chk("up_held_rep", 8'(up_held), 8'h1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("up_held_rel", 8'(up_held), 8'h0);
        pop_exp("rep_p", 3'b101);
        pop_exp("rep_r", 3'b001);
        chk("rep_empty", 8'(evt_valid), 8'h0);

        // five events into a depth-4 FIFO with consumer stalled
        send(8'h29);
        send(8'h75);
        send(8'h72);
        send(8'hF0);
        send(8'h29);
        chk("ovf_before", 8'(overflow), 8'h0);
        send(8'hF0);
        send(8'h75);
        chk("ovf_pulse", 8'(overflow), 8'h1);
        @(negedge clk);
        chk("ovf_clear", 8'(overflow), 8'h0);
        chk("ovf_held", 8'({down_held, up_held, space_held}), 8'h4);
        pop_exp("ovf0", 3'b100);
        pop_exp("ovf1", 3'b101);
        pop_exp("ovf2", 3'b110);
        pop_exp("ovf3", 3'b000);
        chk("ovf_empty", 8'(evt_valid), 8'h0);

        // release down via extended break
        send(8'hE0);
        send(8'hF0);
        send(8'h72);
        pop_exp("dn_rel", 3'b010);
        chk("dn_held0", 8'(down_held), 8'h0);

        // stalled E0 times out; next byte is treated as non-extended
        send(8'hE0);
        repeat (19) @(negedge clk);
        chk("to_early", 8'(seq_abort), 8'h0);
        @(negedge clk);
        chk("to_pulse", 8'(seq_abort), 8'h1);
        @(negedge clk);
        chk("to_clear", 8'(seq_abort), 8'h0);
        send(8'h29);
        pop_exp("to_space", 3'b100);
        send(8'h72);
        pop_exp("to_down", 3'b110);
        chk("to_dn_held", 8'(down_held), 8'h1);

        // byte arriving on the expiry cycle wins over the abort
        send(8'hE0);
        repeat (19) @(negedge clk);
        send(8'h75);
        chk("race_abort", 8'(seq_abort), 8'h0);
        @(negedge clk);
        chk("race_abort2", 8'(seq_abort), 8'h0);
        pop_exp("race_up", 3'b101);

        // full FIFO with simultaneous push and pop
        send(8'hF0);
        send(8'h29);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        send(8'hF0);
        send(8'h72);
        send(8'h29);
        code       = 8'h75;
        code_valid = 1'b1;
        evt_ready  = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        evt_ready  = 1'b0;
        chk("full_ovf", 8'(overflow), 8'h0);
        chk("full_up", 8'(up_held), 8'h1);
        pop_exp("full0", 3'b001);
        pop_exp("full1", 3'b010);
        pop_exp("full2", 3'b100);
        pop_exp("full3", 3'b101);
        chk("full_empty", 8'(evt_valid), 8'h0);

        // asynchronous reset mid-sequence with queued events
        send(8'hF0);
        send(8'h29);
        send(8'hF0);
        send(8'h75);
        send(8'h72);
        send(8'hE0);
        send(8'hF0);
        chk("pre_rst_valid", 8'(evt_valid), 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 8'(evt_valid), 8'h0);
        chk("arst_held", 8'({down_held, up_held, space_held}), 8'h0);
        chk("arst_data", 8'(evt_data), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'hF0);
        send(8'h29);
        chk("post_rst_valid", 8'(evt_valid), 8'h0);
        chk("post_rst_held", 8'(space_held), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
